// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg
// Shared ISA definitions for the instruction loader and the instruction
// type decoder: opcode values, format classes, loader state encoding and
// the opcode-to-class / legality helpers.
package cpu_isa_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0001;
    localparam logic [3:0] OP_ITYPE = 4'b0010;
    localparam logic [3:0] OP_JMP   = 4'b0011;
    localparam logic [3:0] OP_BR    = 4'b0100;
    localparam logic [3:0] OP_LD    = 4'b0101;
    localparam logic [3:0] OP_ST    = 4'b0110;
    localparam logic [3:0] OP_CALL  = 4'b0111;
    localparam logic [3:0] OP_RET   = 4'b1000;
    localparam logic [3:0] OP_EXT0  = 4'b1001;
    localparam logic [3:0] OP_EXT1  = 4'b1010;
    localparam logic [3:0] OP_EXT2  = 4'b1011;

    typedef enum logic [1:0] {
        CLS_RMEM = 2'b00,
        CLS_I    = 2'b01,
        CLS_J    = 2'b10,
        CLS_B    = 2'b11
    } fmt_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_FULL
    } load_state_e;

    // 0000 and 1100-1111 are unassigned.
    function automatic logic op_is_legal(input logic [3:0] op);
        return !((op == 4'b0000) || (op >= 4'b1100));
    endfunction

    // Illegal opcodes fall into CLS_RMEM; callers gate with op_is_legal.
    function automatic fmt_class_e op_class(input logic [3:0] op);
        fmt_class_e cls;
        case (op)
            OP_ITYPE:                 cls = CLS_I;
            OP_JMP, OP_CALL, OP_RET:  cls = CLS_J;
            OP_BR:                    cls = CLS_B;
            default:                  cls = CLS_RMEM;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack
// Combinational encoder: packs symbolic instruction fields into a 16-bit
// word and flags illegal opcodes and immediates that do not fit the format.
// Ports:
//   opcode, fa, fb, fc : 4-bit symbolic fields
//   imm                : 12-bit immediate / target / branch offset
//   word               : packed 16-bit instruction
//   illegal            : opcode unassigned
//   range_err          : immediate not representable in its field
module instr_pack
    import cpu_isa_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  fa,
    input  logic [3:0]  fb,
    input  logic [3:0]  fc,
    input  logic [11:0] imm,
    output logic [15:0] word,
    output logic        illegal,
    output logic        range_err
);

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        illegal   = !op_is_legal(opcode);
        case (op_class(opcode))
            CLS_RMEM: word = {opcode, fa, fb, fc};
            CLS_I: begin
                word      = {opcode, fa, imm[7:0]};
                // signed-8: upper bits must replicate bit 7
                range_err = (imm[11:8] != {4{imm[7]}});
            end
            CLS_J: word = {opcode, imm};
            CLS_B: begin
                word      = {opcode, fa, fb, imm[3:0]};
                // signed-4: upper bits must replicate bit 3
                range_err = (imm[11:4] != {8{imm[3]}});
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader
// Accepts instruction fields over valid/ready, encodes them with instr_pack
// and writes the words sequentially into instruction memory over a req/ack
// port. Sessions are bracketed by start/finish pulses.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   start, finish              : session control pulses
//   in_valid/in_ready, in_*    : instruction field handshake
//   imem_req/addr/wdata/ack    : memory write port
//   wr_count, busy, full, done : session status
//   err_illegal, err_range     : sticky reject flags (cleared on start)
module instr_encode_loader
    import cpu_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_fa,
    input  logic [3:0]        in_fb,
    input  logic [3:0]        in_fc,
    input  logic [11:0]       in_imm,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic              imem_ack,
    output logic [ADDR_W:0]   wr_count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              err_illegal,
    output logic              err_range
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              fin_pend_q, fin_pend_d;
    logic              err_ill_q, err_ill_d;
    logic              err_rng_q, err_rng_d;

    logic [15:0] pk_word;
    logic        pk_illegal;
    logic        pk_range;

    instr_pack u_pack (
        .opcode    (in_opcode),
        .fa        (in_fa),
        .fb        (in_fb),
        .fc        (in_fc),
        .imm       (in_imm),
        .word      (pk_word),
        .illegal   (pk_illegal),
        .range_err (pk_range)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        done_d     = 1'b0;
        fin_pend_d = fin_pend_q;
        err_ill_d  = err_ill_q;
        err_rng_d  = err_rng_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ACCEPT;
                    ptr_d      = BASE;
                    count_d    = '0;
                    err_ill_d  = 1'b0;
                    err_rng_d  = 1'b0;
                    fin_pend_d = 1'b0;
                end
            end
            ST_ACCEPT: begin
                // finish beats both restart and a same-cycle transfer
                if (finish) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (start) begin
                    ptr_d      = BASE;
                    count_d    = '0;
                    err_ill_d  = 1'b0;
                    err_rng_d  = 1'b0;
                    fin_pend_d = 1'b0;
                end else if (in_valid) begin
                    if (pk_illegal) begin
                        err_ill_d = 1'b1;
                    end else if (pk_range) begin
                        err_rng_d = 1'b1;
                    end else begin
                        addr_d     = ptr_q;
                        wdata_d    = pk_word;
                        fin_pend_d = 1'b0;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (finish) begin
                    fin_pend_d = 1'b1;
                end
                if (imem_ack) begin
                    ptr_d      = ptr_q + 1'b1;
                    count_d    = count_q + 1'b1;
                    fin_pend_d = 1'b0;
                    // a finish seen anywhere in this write, including the
                    // ack cycle itself, ends the session after the word
                    if (fin_pend_q || finish) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if ((count_q + 1'b1) == DEPTH_CNT) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            ST_FULL: begin
                if (finish) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (start) begin
                    state_d    = ST_ACCEPT;
                    ptr_d      = BASE;
                    count_d    = '0;
                    err_ill_d  = 1'b0;
                    err_rng_d  = 1'b0;
                    fin_pend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= BASE;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            fin_pend_q <= 1'b0;
            err_ill_q  <= 1'b0;
            err_rng_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            done_q     <= done_d;
            fin_pend_q <= fin_pend_d;
            err_ill_q  <= err_ill_d;
            err_rng_q  <= err_rng_d;
        end
    end

    assign in_ready    = (state_q == ST_ACCEPT);
    assign imem_req    = (state_q == ST_WRITE);
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign wr_count    = count_q;
    assign busy        = (state_q != ST_IDLE);
    assign full        = (state_q == ST_FULL);
    assign done        = done_q;
    assign err_illegal = err_ill_q;
    assign err_range   = err_rng_q;

endmodule
